// File: rtl/div_pkg.sv
// Shared constants and FSM state encoding for the fixed-point divider.
package div_pkg;

  localparam int unsigned WIDTH = 10;
  localparam int unsigned FRAC  = 4;
  localparam int unsigned ITER  = WIDTH + FRAC;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t CALC = 2'd1;
  localparam state_t DONE = 2'd2;

endpackage

// File: rtl/div_datapath.sv
// Restoring shift-subtract datapath: remainder, dividend/quotient shift
// register, latched divisor and iteration counter.
module div_datapath #(
  parameter int unsigned WIDTH = div_pkg::WIDTH,
  parameter int unsigned FRAC  = div_pkg::FRAC
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic                    step_i,
  input  logic [WIDTH-1:0]        a_i,
  input  logic [WIDTH-1:0]        b_i,
  output logic [WIDTH+FRAC-1:0]   quo_o,
  output logic                    div_zero_o,
  output logic                    last_o
);

  localparam int unsigned ITERS = WIDTH + FRAC;
  localparam int unsigned CNT_W = $clog2(ITERS + 1);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [ITERS-1:0] dq_q, dq_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_diff;
  logic             ge;

  // Trial subtraction of the divisor from the shifted partial remainder.
  // The true difference is below the divisor, so the low WIDTH bits suffice.
  always_comb begin
    rem_sh   = {rem_q, dq_q[ITERS-1]};
    ge       = (rem_sh >= {1'b0, dvs_q});
    rem_diff = rem_sh[WIDTH-1:0] - dvs_q;
  end

  // Next-state: load operands, or perform one restoring iteration.
  // Dividend bits shift out of the top of dq while quotient bits enter below.
  always_comb begin
    rem_d = rem_q;
    dq_d  = dq_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    if (load_i) begin
      rem_d = '0;
      dq_d  = {a_i, {FRAC{1'b0}}};
      dvs_d = b_i;
      cnt_d = '0;
    end else if (step_i) begin
      rem_d = ge ? rem_diff : rem_sh[WIDTH-1:0];
      dq_d  = {dq_q[ITERS-2:0], ge};
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rem_q <= '0;
      dq_q  <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      dq_q  <= dq_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

  assign quo_o      = dq_q;
  assign div_zero_o = (dvs_q == '0);
  assign last_o     = (cnt_q == CNT_W'(ITERS - 1));

endmodule

// File: rtl/div_top.sv
// Unsigned fixed-point divider: Q = floor((A << FRAC) / B), saturating,
// with divide-by-zero detection. FSM here, arithmetic in div_datapath.
module div_top #(
  parameter int unsigned WIDTH = div_pkg::WIDTH,
  parameter int unsigned FRAC  = div_pkg::FRAC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             valid,
  output logic             ov,
  output logic             dvz
);

  import div_pkg::*;

  localparam int unsigned ITERS = WIDTH + FRAC;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             valid_q, valid_d;
  logic             ov_q, ov_d;
  logic             dvz_q, dvz_d;

  logic             load, step, last, div_zero;
  logic [ITERS-1:0] quo_raw;
  logic             quo_ov;

  div_datapath #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_datapath (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .step_i     (step),
    .a_i        (A),
    .b_i        (B),
    .quo_o      (quo_raw),
    .div_zero_o (div_zero),
    .last_o     (last)
  );

  assign quo_ov = |quo_raw[ITERS-1:WIDTH];

  // Control FSM. Results are registered one cycle after entering DONE, so
  // valid rises at k+15 for a real division and k+1 for a zero divisor.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    valid_d = valid_q;
    ov_d    = ov_q;
    dvz_d   = dvz_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      CALC: begin
        step = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        valid_d = 1'b1;
        dvz_d   = div_zero;
        ov_d    = !div_zero && quo_ov;
        if (div_zero)    q_d = '0;
        else if (quo_ov) q_d = '1;
        else             q_d = quo_raw[WIDTH-1:0];
      end
      default: state_d = IDLE;
    endcase
    // A start is honoured in IDLE and DONE and overrides the DONE update.
    if (start && (state_q == IDLE || state_q == DONE)) begin
      load    = 1'b1;
      q_d     = '0;
      valid_d = 1'b0;
      ov_d    = 1'b0;
      dvz_d   = 1'b0;
      state_d = (B == '0) ? DONE : CALC;
    end
  end

  // Control and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      valid_q <= 1'b0;
      ov_q    <= 1'b0;
      dvz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      valid_q <= valid_d;
      ov_q    <= ov_d;
      dvz_q   <= dvz_d;
    end
  end

  assign Q     = q_q;
  assign busy  = (state_q == CALC);
  assign valid = valid_q;
  assign ov    = ov_q;
  assign dvz   = dvz_q;

endmodule

// File: tb/tb_div_top.sv
// Directed and randomized bench for div_top against an arithmetic model.
module tb_div_top;

  localparam int W = 10;
  localparam int F = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A, B, Q;
  logic         busy, valid, ov, dvz;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  div_top #(.WIDTH(W), .FRAC(F)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Q     (Q),
    .busy  (busy),
    .valid (valid),
    .ov    (ov),
    .dvz   (dvz)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: fixed-point quotient with saturation and zero-divisor rule.
  function automatic void model(input int a, input int b,
                                output int q, output int o, output int z);
    int raw;
    q = 0; o = 0; z = 0;
    if (b == 0) begin
      z = 1;
    end else begin
      raw = (a * (1 << F)) / b;
      if (raw > (1 << W) - 1) begin
        q = (1 << W) - 1;
        o = 1;
      end else begin
        q = raw;
      end
    end
  endfunction

  task automatic run(input int a, input int b, input bit disturb, input string tag);
    int eq, eo, ez, lat, bcnt;
    model(a, b, eq, eo, ez);
    A = W'(a);
    B = W'(b);
    start = 1'b1;
    tick;
    start = 1'b0;
    check({tag, " valid-cleared"}, valid, 0);
    bcnt = busy ? 1 : 0;
    lat  = 0;
    while (!valid && lat < 40) begin
      if (disturb) begin
        start = (lat == 5);
        A = W'($urandom);
        B = W'($urandom);
      end
      tick;
      lat++;
      if (!valid && busy) bcnt++;
    end
    start = 1'b0;
    check({tag, " latency"}, lat, (b == 0) ? 1 : 15);
    check({tag, " busy-cycles"}, bcnt, (b == 0) ? 0 : 14);
    check({tag, " valid"}, valid, 1);
    check({tag, " Q"}, Q, eq);
    check({tag, " ov"}, ov, eo);
    check({tag, " dvz"}, dvz, ez);
    A = W'($urandom);
    B = W'($urandom);
    repeat (3) tick;
    check({tag, " Q-held"}, Q, eq);
    check({tag, " valid-held"}, valid, 1);
    check({tag, " busy-idle"}, busy, 0);
  endtask

  initial begin
    int a, b, vseen;
    rst = 1'b0; start = 1'b0; A = '0; B = '0;
    repeat (3) tick;
    check("reset Q", Q, 0);
    check("reset busy", busy, 0);
    check("reset valid", valid, 0);
    check("reset ov", ov, 0);
    check("reset dvz", dvz, 0);
    rst = 1'b1;
    tick;

    run(10'b1101010000, 0, 1'b0, "dvz");
    run(100, 16, 1'b0, "100/16");
    run(215, 24, 1'b0, "215/24");
    run(237, 8, 1'b0, "237/8");
    run(508, 8, 1'b0, "508/8");
    run(1023, 1, 1'b0, "1023/1");
    run(100, 16, 1'b1, "disturb 100/16");
    run(777, 3, 1'b1, "disturb 777/3");

    // Abort mid-iteration: outputs clear, no valid afterwards.
    A = 10'd100; B = 10'd16; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (7) tick;
    check("abort busy-before", busy, 1);
    rst = 1'b0;
    tick;
    check("abort Q", Q, 0);
    check("abort busy", busy, 0);
    check("abort valid", valid, 0);
    check("abort ov", ov, 0);
    check("abort dvz", dvz, 0);
    rst = 1'b1;
    vseen = 0;
    repeat (20) begin
      tick;
      if (valid || busy) vseen++;
    end
    check("abort no-valid", vseen, 0);

    // Start coincident with reset is dropped.
    rst = 1'b0; start = 1'b1; A = 10'd100; B = 10'd16;
    tick;
    rst = 1'b1; start = 1'b0;
    check("rst+start busy", busy, 0);
    tick;
    check("rst+start busy-later", busy, 0);
    check("rst+start valid", valid, 0);
    run(100, 16, 1'b0, "after-reset 100/16");

    for (int i = 0; i < 25; i++) begin
      a = $urandom_range(0, (1 << W) - 1);
      if (i % 8 == 0)      b = 0;
      else if (i % 3 == 0) b = $urandom_range(1, 15);
      else                 b = $urandom_range(1, (1 << W) - 1);
      run(a, b, (i % 4 == 1), "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
